// File: rtl/fifo_ctrl_pkg.sv
// rtl/fifo_ctrl_pkg.sv - shared types and width helpers for the FIFO write controller
package fifo_ctrl_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int idx_w(input int num_req);
        return $clog2(num_req);
    endfunction

    localparam int PTR_W = ptr_w(16);
    localparam int IDX_W = idx_w(4);

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting after the last grant
module rr_arbiter
    import fifo_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]          req,
    input  logic [idx_w(NUM_REQ)-1:0]   last_grant,
    output logic [idx_w(NUM_REQ)-1:0]   winner,
    output logic                        any_req
);

    localparam int IW = idx_w(NUM_REQ);

    logic          found;
    logic [IW-1:0] cand;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IW'((int'(last_grant) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst-limited sharing of one FIFO write port
module fifo_wr_arbiter
    import fifo_ctrl_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 16,
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]    req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic                        read_en,
    output logic                        write_en,
    output logic [WIDTH-1:0]            data_in,
    output logic [ptr_w(DEPTH)-1:0]     waddr,
    output logic [ptr_w(DEPTH)-1:0]     raddr,
    output logic                        full,
    output logic                        empty,
    output logic [ptr_w(DEPTH)-1:0]     count,
    output logic [idx_w(NUM_REQ)-1:0]   grant_id,
    output logic                        busy
);

    localparam int PW = ptr_w(DEPTH);
    localparam int IW = idx_w(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST) + 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

    state_t        state_q, state_d;
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [IW-1:0] grant_q, grant_d, winner;
    logic [BW-1:0] beat_q, beat_d;
    logic          any_req, in_grant, sel_valid, beat, pop;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req        (req_valid),
        .last_grant (grant_q),
        .winner     (winner),
        .any_req    (any_req)
    );

    assign empty     = (wptr_q == rptr_q);
    assign full      = (wptr_q[PW-1] != rptr_q[PW-1]) && (wptr_q[PW-2:0] == rptr_q[PW-2:0]);
    assign count     = wptr_q - rptr_q;
    assign waddr     = wptr_q;
    assign raddr     = rptr_q;
    assign grant_id  = grant_q;
    assign in_grant  = (state_q == GRANT);
    assign busy      = in_grant;
    assign sel_valid = req_valid[grant_q];
    // Ready looks at the registered full flag, so a same-cycle pop never unblocks a write.
    assign beat      = in_grant && sel_valid && !full;
    assign pop       = read_en && !empty;
    assign write_en  = beat;
    assign data_in   = req_data[int'(grant_q)*WIDTH +: WIDTH];

    always_comb begin
        req_ready = '0;
        if (in_grant && !full) begin
            req_ready[grant_q] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        beat_d  = beat_q;
        wptr_d  = wptr_q + PW'(beat);
        rptr_d  = rptr_q + PW'(pop);
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d = winner;
                    beat_d  = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (beat) begin
                    beat_d = beat_q + 1'b1;
                end
                if (!sel_valid || (beat && beat_q == LAST_BEAT)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            grant_q <= IW'(NUM_REQ - 1);
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            grant_q <= grant_d;
            beat_q  <= beat_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int W  = 32;
    localparam int D  = 16;
    localparam int MB = 4;
    localparam int PW = 5;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR*W-1:0]   req_data;
    logic [NR-1:0]     req_ready;
    logic              read_en;
    logic              write_en;
    logic [W-1:0]      data_in;
    logic [PW-1:0]     waddr, raddr, count;
    logic              full, empty, busy;
    logic [IW-1:0]     grant_id;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.WIDTH(W), .DEPTH(D), .NUM_REQ(NR), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .read_en(read_en), .write_en(write_en),
        .data_in(data_in), .waddr(waddr), .raddr(raddr), .full(full),
        .empty(empty), .count(count), .grant_id(grant_id), .busy(busy)
    );

    typedef struct {
        logic [NR-1:0] v;
        logic          re;
        logic          we;
        logic [NR-1:0] rdy;
        logic          bsy;
        int            gid;
        int            cnt;
    } tv_t;

    tv_t tv[20];

    int total = 0;
    int bad   = 0;

    // Reference: FIFO contents as a queue, pointers as free-running counts.
    logic [W-1:0] q[$];
    logic [W-1:0] mem[D];
    int m_wr, m_rd, m_owner, m_beats;
    bit m_busy;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_wr = 0; m_rd = 0; m_owner = NR - 1; m_beats = 0; m_busy = 0;
    endtask

    function automatic bit m_we();
        return m_busy && req_valid[m_owner] && (q.size() < D);
    endfunction

    task automatic drive(input logic [NR-1:0] v, input logic re, input logic r);
        req_valid = v;
        read_en   = re;
        rst       = r;
        for (int i = 0; i < NR; i++) req_data[i*W +: W] = $urandom;
    endtask

    // Called at the falling edge: compare against the model, advance it, move past the rising edge.
    task automatic step();
        logic [NR-1:0] one;
        logic [NR-1:0] er;
        bit we, rd;
        one = 1;
        we  = m_we();
        er  = (m_busy && q.size() < D) ? (one << m_owner) : '0;
        rd  = read_en && (q.size() > 0);
        chk("ready", req_ready, er);
        chk("write_en", write_en, we);
        if (we) chk("data_in", data_in, req_data[m_owner*W +: W]);
        chk("waddr", waddr, m_wr);
        chk("raddr", raddr, m_rd);
        chk("count", count, q.size());
        chk("full", full, q.size() == D);
        chk("empty", empty, q.size() == 0);
        chk("grant_id", grant_id, m_owner);
        chk("busy", busy, m_busy);
        if (rd && !rst) chk("read_order", mem[m_rd % D], q[0]);
        if (write_en) mem[waddr[3:0]] = data_in;
        if (rst) begin
            model_reset();
        end else begin
            if (rd) begin
                void'(q.pop_front());
                m_rd = (m_rd + 1) % 32;
            end
            if (we) begin
                q.push_back(req_data[m_owner*W +: W]);
                m_wr = (m_wr + 1) % 32;
            end
            if (m_busy) begin
                if (!req_valid[m_owner] || (we && m_beats == MB - 1)) m_busy = 0;
                if (we) m_beats++;
            end else if (req_valid != '0) begin
                for (int k = 1; k <= NR; k++) begin
                    if (req_valid[(m_owner + k) % NR]) begin
                        m_owner = (m_owner + k) % NR;
                        break;
                    end
                end
                m_beats = 0;
                m_busy  = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input logic [NR-1:0] v, input logic re, input logic r);
        drive(v, re, r);
        @(negedge clk);
        step();
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() > 0; i++) tick('0, 1'b1, 1'b0);
        chk("drained_empty", empty, 1);
    endtask

    initial begin
        logic [NR-1:0] rv;
        int n, ws, rs;

        // Four grants of four beats each, one idle bubble before each grant.
        for (int i = 0; i < 20; i++) begin
            int g, ph;
            g = i / 5;
            ph = i % 5;
            tv[i].v  = 4'b1111;
            tv[i].re = 1'b0;
            if (ph == 0) begin
                tv[i].we = 0; tv[i].rdy = '0; tv[i].bsy = 0;
                tv[i].gid = (g == 0) ? 3 : g - 1;
                tv[i].cnt = 4 * g;
            end else begin
                tv[i].we = 1; tv[i].rdy = 4'b0001 << g; tv[i].bsy = 1;
                tv[i].gid = g;
                tv[i].cnt = 4 * g + ph - 1;
            end
        end

        rst = 1'b1; req_valid = '0; req_data = '0; read_en = 1'b0;
        for (int i = 0; i < D; i++) mem[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        drive('0, 1'b0, 1'b0);
        @(negedge clk);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_grant", grant_id, 3);
        chk("rst_busy", busy, 0);
        step();

        for (int i = 0; i < 20; i++) begin
            drive(tv[i].v, tv[i].re, 1'b0);
            @(negedge clk);
            chk($sformatf("tv%0d_we", i), write_en, tv[i].we);
            chk($sformatf("tv%0d_ready", i), req_ready, tv[i].rdy);
            chk($sformatf("tv%0d_busy", i), busy, tv[i].bsy);
            chk($sformatf("tv%0d_grant", i), grant_id, tv[i].gid);
            chk($sformatf("tv%0d_count", i), count, tv[i].cnt);
            step();
        end

        // Full stall with requester 2 holding the grant.
        drive(4'b0100, 1'b0, 1'b0);
        @(negedge clk);
        chk("full_after16", full, 1);
        chk("count_after16", count, 16);
        step();
        drive(4'b0100, 1'b0, 1'b0);
        @(negedge clk);
        chk("stall_ready", req_ready, 0);
        chk("stall_we", write_en, 0);
        chk("stall_grant", grant_id, 2);
        chk("stall_busy", busy, 1);
        step();
        tick(4'b0100, 1'b1, 1'b0);
        drive(4'b0100, 1'b0, 1'b0);
        @(negedge clk);
        chk("unstall_ready", req_ready, 4'b0100);
        chk("unstall_we", write_en, 1);
        chk("unstall_waddr", waddr, 16);
        chk("unstall_raddr", raddr, 1);
        step();
        drive(4'b0100, 1'b0, 1'b0);
        @(negedge clk);
        chk("refull", full, 1);
        chk("refull_ready", req_ready, 0);
        step();
        drain();

        // Early release: requester 1 sends two beats then drops valid.
        tick(4'b0010, 1'b0, 1'b0);
        drive(4'b0010, 1'b0, 1'b0);
        req_data[1*W +: W] = 32'hA;
        @(negedge clk);
        chk("early_we_a", write_en, 1);
        chk("early_data_a", data_in, 32'hA);
        chk("early_grant", grant_id, 1);
        step();
        drive(4'b0010, 1'b0, 1'b0);
        req_data[1*W +: W] = 32'hB;
        @(negedge clk);
        chk("early_data_b", data_in, 32'hB);
        step();
        drive(4'b0100, 1'b0, 1'b0);
        @(negedge clk);
        chk("early_drop_we", write_en, 0);
        step();
        drive(4'b0100, 1'b0, 1'b0);
        @(negedge clk);
        chk("early_idle", busy, 0);
        chk("early_count", count, 2);
        step();
        drive(4'b0100, 1'b0, 1'b0);
        @(negedge clk);
        chk("early_next_grant", grant_id, 2);
        chk("early_next_busy", busy, 1);
        step();
        drain();

        // Simultaneous read and write at occupancy 5.
        for (int i = 0; i < 20 && q.size() < 5; i++) tick(4'b0001, 1'b0, 1'b0);
        chk("sim_pre_count", count, 5);
        ws = m_wr; rs = m_rd; n = 0;
        for (int i = 0; i < 40 && n < 10; i++) begin
            drive(4'b0001, 1'b0, 1'b0);
            read_en = m_we();
            if (read_en) n++;
            @(negedge clk);
            step();
        end
        chk("sim_beats", n, 10);
        chk("sim_count", count, 5);
        chk("sim_waddr", waddr, (ws + 10) % 32);
        chk("sim_raddr", raddr, (rs + 10) % 32);
        drain();

        // Read while empty, then reset on the third beat of a burst.
        rs = m_rd;
        tick('0, 1'b1, 1'b0);
        tick('0, 1'b1, 1'b0);
        chk("empty_read_raddr", raddr, rs);
        tick(4'b0001, 1'b0, 1'b0);
        tick(4'b0001, 1'b0, 1'b0);
        tick(4'b0001, 1'b0, 1'b0);
        drive(4'b0001, 1'b0, 1'b1);
        @(negedge clk);
        chk("rst_beat3_we", write_en, 1);
        step();
        chk("midrst_busy", busy, 0);
        chk("midrst_waddr", waddr, 0);
        chk("midrst_raddr", raddr, 0);
        chk("midrst_empty", empty, 1);
        chk("midrst_grant", grant_id, 3);

        // Randomized traffic against the reference model.
        rv = '0;
        for (int i = 0; i < 800; i++) begin
            for (int b = 0; b < NR; b++) if ($urandom_range(0, 5) == 0) rv[b] = ~rv[b];
            tick(rv, (i < 400) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0),
                 $urandom_range(0, 299) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
